// File: rtl/main_ram_arbiter_pkg.sv
// Shared definitions for the main RAM arbiter and its requesters:
// bus widths, port ids, starvation limit default and bus payload types.
package main_ram_arbiter_pkg;

  localparam int unsigned ADDR_W              = 15;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned BSEL_W              = 4;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    PORT_P0 = 2'd0,
    PORT_P1 = 2'd1,
    PORT_P2 = 2'd2
  } port_id_e;

  // One RAM access as presented on the registered RAM bus
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic [BSEL_W-1:0] wrbytesel;
    logic              write;
  } ram_cmd_t;

  // Read-return tracking tag carried down the valid pipeline
  typedef struct packed {
    logic     read;
    port_id_e port;
  } rd_tag_t;

endpackage

// File: rtl/main_ram_arbiter.sv
// Three-port single-RAM arbiter: display port p0 has priority with a starvation
// override, p1/p2 share round-robin; one access per cycle, reads return at N+2.
module main_ram_arbiter
  import main_ram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ack,
  output logic              p0_rddata_valid,

  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wrdata,
  input  logic [BSEL_W-1:0] p1_wrbytesel,
  input  logic              p1_write,
  output logic              p1_ack,
  output logic              p1_rddata_valid,

  input  logic              p2_req,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [DATA_W-1:0] p2_wrdata,
  input  logic [BSEL_W-1:0] p2_wrbytesel,
  input  logic              p2_write,
  output logic              p2_ack,
  output logic              p2_rddata_valid,

  output logic [DATA_W-1:0] rddata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wrdata,
  output logic [BSEL_W-1:0] ram_wrbytesel,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_rddata
);

  localparam int unsigned CNT_RAW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 4) ? CNT_RAW : 4;
  localparam logic        RR_P1   = 1'b0;
  localparam logic        RR_P2   = 1'b1;

  logic [CNT_W-1:0] starve_cnt;
  logic             rr_last;
  rd_tag_t          tag_s1;

  logic     p12_req;
  logic     starve_hit;
  logic     rr_pick_p2;
  logic     grant_vld;
  port_id_e grant_port;
  ram_cmd_t cmd;

  // Grant decision; held off entirely while in reset
  always_comb begin
    grant_vld  = 1'b0;
    grant_port = PORT_P0;
    p12_req    = p1_req | p2_req;
    starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
    rr_pick_p2 = p2_req && (!p1_req || (rr_last == RR_P1));
    if (rst_n) begin
      if (p0_req && !(starve_hit && p12_req)) begin
        grant_vld  = 1'b1;
        grant_port = PORT_P0;
      end else if (p12_req) begin
        grant_vld  = 1'b1;
        grant_port = rr_pick_p2 ? PORT_P2 : PORT_P1;
      end
    end
  end

  assign p0_ack = grant_vld && (grant_port == PORT_P0);
  assign p1_ack = grant_vld && (grant_port == PORT_P1);
  assign p2_ack = grant_vld && (grant_port == PORT_P2);
  assign rddata = ram_rddata;

  // Command mux; the display port is read-only and leaves write data untouched
  always_comb begin
    cmd = '0;
    unique case (grant_port)
      PORT_P0: begin
        cmd.addr      = p0_addr;
        cmd.wrdata    = ram_wrdata;
        cmd.wrbytesel = '0;
        cmd.write     = 1'b0;
      end
      PORT_P1: begin
        cmd.addr      = p1_addr;
        cmd.wrdata    = p1_wrdata;
        cmd.wrbytesel = p1_wrbytesel;
        cmd.write     = p1_write;
      end
      PORT_P2: begin
        cmd.addr      = p2_addr;
        cmd.wrdata    = p2_wrdata;
        cmd.wrbytesel = p2_wrbytesel;
        cmd.write     = p2_write;
      end
      default: cmd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr        <= '0;
      ram_wrdata      <= '0;
      ram_wrbytesel   <= '0;
      ram_write       <= 1'b0;
      starve_cnt      <= '0;
      rr_last         <= RR_P2;
      tag_s1          <= '0;
      p0_rddata_valid <= 1'b0;
      p1_rddata_valid <= 1'b0;
      p2_rddata_valid <= 1'b0;
    end else begin
      if (grant_vld) begin
        ram_addr      <= cmd.addr;
        ram_wrdata    <= cmd.wrdata;
        ram_wrbytesel <= cmd.wrbytesel;
        ram_write     <= cmd.write;
      end else begin
        ram_wrbytesel <= '0;
        ram_write     <= 1'b0;
      end

      // Counts p0 wins while p1/p2 wait; any other outcome breaks the run
      if (grant_vld && (grant_port == PORT_P0) && p12_req) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end

      if (grant_vld && (grant_port != PORT_P0)) begin
        rr_last <= (grant_port == PORT_P2) ? RR_P2 : RR_P1;
      end

      tag_s1.read     <= grant_vld && !cmd.write;
      tag_s1.port     <= grant_port;
      p0_rddata_valid <= tag_s1.read && (tag_s1.port == PORT_P0);
      p1_rddata_valid <= tag_s1.read && (tag_s1.port == PORT_P1);
      p2_rddata_valid <= tag_s1.read && (tag_s1.port == PORT_P2);
    end
  end

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Self-checking bench for main_ram_arbiter: directed vector table, corner
// sequences and randomized traffic checked against a behavioural model.
module tb_main_ram_arbiter;
  import main_ram_arbiter_pkg::*;

  localparam int LIMIT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req, p1_req, p2_req;
  logic [14:0] p0_addr, p1_addr, p2_addr;
  logic [31:0] p1_wrdata, p2_wrdata;
  logic [3:0]  p1_wrbytesel, p2_wrbytesel;
  logic        p1_write, p2_write;
  logic        p0_ack, p1_ack, p2_ack;
  logic        p0_rddata_valid, p1_rddata_valid, p2_rddata_valid;
  logic [31:0] rddata, ram_wrdata, ram_rddata;
  logic [14:0] ram_addr;
  logic [3:0]  ram_wrbytesel;
  logic        ram_write;

  main_ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rddata_valid(p0_rddata_valid),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wrdata(p1_wrdata), .p1_wrbytesel(p1_wrbytesel),
    .p1_write(p1_write), .p1_ack(p1_ack), .p1_rddata_valid(p1_rddata_valid),
    .p2_req(p2_req), .p2_addr(p2_addr), .p2_wrdata(p2_wrdata), .p2_wrbytesel(p2_wrbytesel),
    .p2_write(p2_write), .p2_ack(p2_ack), .p2_rddata_valid(p2_rddata_valid),
    .rddata(rddata), .ram_addr(ram_addr), .ram_wrdata(ram_wrdata),
    .ram_wrbytesel(ram_wrbytesel), .ram_write(ram_write), .ram_rddata(ram_rddata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the address
  logic [31:0] mem    [0:32767];
  logic [31:0] shadow [0:32767];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] bsel);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (bsel[b]) w[b*8 +: 8] = d[b*8 +: 8];
    return w;
  endfunction

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= merge(mem[ram_addr], ram_wrdata, ram_wrbytesel);
    ram_rddata <= mem[ram_addr];
  end

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Reference model state
  typedef struct { int due; int port; logic [31:0] data; } rd_t;
  rd_t         pend[$];
  int          deny_run, last_p12, cyc, total, bad;
  logic [14:0] exp_addr;
  logic [31:0] exp_wrdata;
  logic [3:0]  exp_bsel;
  logic        exp_write;

  logic [2:0]  snap_ack, snap_vld;
  logic [31:0] snap_rd;
  logic [14:0] snap_addr;
  logic [3:0]  snap_bsel;
  logic        snap_write;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int predict();
    bit p12;
    p12 = p1_req || p2_req;
    if (p0_req && !(p12 && deny_run >= LIMIT)) return 0;
    if (p1_req && p2_req) return (last_p12 == 1) ? 2 : 1;
    if (p1_req) return 1;
    if (p2_req) return 2;
    return -1;
  endfunction

  // One clock cycle: inputs already driven; check at negedge, then advance
  task automatic step(output int g);
    int ev;
    logic [31:0] edata;
    @(negedge clk);
    g = predict();
    snap_ack   = {p2_ack, p1_ack, p0_ack};
    snap_vld   = {p2_rddata_valid, p1_rddata_valid, p0_rddata_valid};
    snap_rd    = rddata;
    snap_addr  = ram_addr;
    snap_bsel  = ram_wrbytesel;
    snap_write = ram_write;
    chk("p0_ack", 32'(p0_ack), 32'(g == 0));
    chk("p1_ack", 32'(p1_ack), 32'(g == 1));
    chk("p2_ack", 32'(p2_ack), 32'(g == 2));
    chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
    chk("ram_wrdata", ram_wrdata, exp_wrdata);
    chk("ram_wrbytesel", 32'(ram_wrbytesel), 32'(exp_bsel));
    chk("ram_write", 32'(ram_write), 32'(exp_write));
    ev = -1;
    edata = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = pend[0].port;
      edata = pend[0].data;
      void'(pend.pop_front());
    end
    chk("p0_rddata_valid", 32'(p0_rddata_valid), 32'(ev == 0));
    chk("p1_rddata_valid", 32'(p1_rddata_valid), 32'(ev == 1));
    chk("p2_rddata_valid", 32'(p2_rddata_valid), 32'(ev == 2));
    if (ev >= 0) chk("rddata", rddata, edata);

    if (g == 0 && (p1_req || p2_req)) deny_run++;
    else deny_run = 0;
    case (g)
      0: begin
        exp_addr = p0_addr; exp_bsel = '0; exp_write = 1'b0;
        pend.push_back('{cyc + 2, 0, shadow[p0_addr]});
      end
      1: begin
        exp_addr = p1_addr; exp_wrdata = p1_wrdata; exp_bsel = p1_wrbytesel;
        exp_write = p1_write; last_p12 = 1;
        if (p1_write) shadow[p1_addr] = merge(shadow[p1_addr], p1_wrdata, p1_wrbytesel);
        else pend.push_back('{cyc + 2, 1, shadow[p1_addr]});
      end
      2: begin
        exp_addr = p2_addr; exp_wrdata = p2_wrdata; exp_bsel = p2_wrbytesel;
        exp_write = p2_write; last_p12 = 2;
        if (p2_write) shadow[p2_addr] = merge(shadow[p2_addr], p2_wrdata, p2_wrbytesel);
        else pend.push_back('{cyc + 2, 2, shadow[p2_addr]});
      end
      default: begin
        exp_bsel = '0; exp_write = 1'b0;
      end
    endcase
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One-cycle reset pulse, entered just after a rising edge
  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_acks", 32'({p2_ack, p1_ack, p0_ack}), 32'd0);
    chk("rst_valids", 32'({p2_rddata_valid, p1_rddata_valid, p0_rddata_valid}), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wrdata", ram_wrdata, 32'd0);
    chk("rst_ram_bsel_write", 32'({ram_wrbytesel, ram_write}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    deny_run = 0; last_p12 = 2; pend.delete();
    exp_addr = '0; exp_wrdata = '0; exp_bsel = '0; exp_write = 1'b0;
  endtask

  task automatic set_req(input logic r0, input logic r1, input logic r2);
    p0_req = r0; p1_req = r1; p2_req = r2;
  endtask

  function automatic logic [14:0] rnd_addr();
    logic [14:0] a;
    a = 15'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) a = a | 15'h4000;
    return a;
  endfunction

  typedef struct { logic [2:0] req; logic [2:0] ack; } vec_t;
  vec_t tbl[12];

  initial begin
    int g;
    logic [14:0] a0;
    logic [2:0] req_v;
    total = 0; bad = 0; cyc = 0;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = init_word(i);
      shadow[i] = init_word(i);
    end
    set_req(0, 0, 0);
    p0_addr = '0; p1_addr = '0; p2_addr = '0;
    p1_wrdata = '0; p2_wrdata = '0; p1_wrbytesel = '0; p2_wrbytesel = '0;
    p1_write = 0; p2_write = 0;
    apply_reset();

    // {p2,p1,p0} request patterns from reset and the one-hot ack each must produce
    tbl[0]  = '{3'b000, 3'b000}; tbl[1]  = '{3'b110, 3'b010};
    tbl[2]  = '{3'b110, 3'b100}; tbl[3]  = '{3'b110, 3'b010};
    tbl[4]  = '{3'b100, 3'b100}; tbl[5]  = '{3'b110, 3'b010};
    tbl[6]  = '{3'b111, 3'b001}; tbl[7]  = '{3'b001, 3'b001};
    tbl[8]  = '{3'b010, 3'b010}; tbl[9]  = '{3'b101, 3'b001};
    tbl[10] = '{3'b100, 3'b100}; tbl[11] = '{3'b000, 3'b000};
    for (int i = 0; i < 12; i++) begin
      req_v = tbl[i].req;
      set_req(req_v[0], req_v[1], req_v[2]);
      p0_addr = 15'(16'h0200 + i); p1_addr = 15'(16'h0300 + i); p2_addr = 15'(16'h0400 + i);
      step(g);
      chk("tbl_ack", 32'(snap_ack), 32'(tbl[i].ack));
    end
    set_req(0, 0, 0);
    step(g); step(g);

    // Single p0 read: ack N, address N+1, data N+2
    apply_reset();
    set_req(1, 0, 0); p0_addr = 15'h0100;
    step(g); chk("p0_read_ack", 32'(snap_ack), 32'b001);
    set_req(0, 0, 0);
    step(g); chk("p0_read_addr", 32'(snap_addr), 32'h0100);
    step(g); chk("p0_read_valid", 32'(snap_vld), 32'b001);
    chk("p0_read_data", snap_rd, init_word(16'h0100));

    // Continuous p1/p2 writes alternate starting with p1
    apply_reset();
    set_req(0, 1, 1);
    p1_write = 1; p1_wrbytesel = 4'hF; p1_wrdata = 32'hCAFE_0001; p1_addr = 15'h0500;
    p2_write = 1; p2_wrbytesel = 4'h3; p2_wrdata = 32'hBEEF_0002; p2_addr = 15'h0501;
    for (int k = 0; k < 8; k++) begin
      step(g);
      chk("rr_ack", 32'(snap_ack), (k % 2 == 0) ? 32'b010 : 32'b100);
      if (k > 0) begin
        chk("rr_write", 32'(snap_write), 32'd1);
        chk("rr_bsel", 32'(snap_bsel), ((k - 1) % 2 == 0) ? 32'hF : 32'h3);
      end
    end
    set_req(0, 0, 0); p1_write = 0; p2_write = 0;
    step(g);

    // p0 vs p1 contention: p1 breaks through every 16th cycle
    apply_reset();
    set_req(1, 1, 0); p0_addr = 15'h0040; p1_addr = 15'h0041;
    for (int k = 0; k < 48; k++) begin
      step(g);
      chk("starve_ack", 32'(snap_ack), (k % 16 == 15) ? 32'b010 : 32'b001);
    end
    set_req(0, 0, 0);
    step(g); step(g);

    // Back-to-back reads from three ports return in order
    apply_reset();
    set_req(1, 0, 0); p0_addr = 15'h0010; step(g);
    set_req(0, 1, 0); p1_addr = 15'h4010; step(g);
    set_req(0, 0, 1); p2_addr = 15'h0020; step(g);
    chk("b2b_v0", 32'(snap_vld), 32'b001); chk("b2b_d0", snap_rd, shadow[15'h0010]);
    set_req(0, 0, 0); step(g);
    chk("b2b_v1", 32'(snap_vld), 32'b010); chk("b2b_d1", snap_rd, shadow[15'h4010]);
    step(g);
    chk("b2b_v2", 32'(snap_vld), 32'b100); chk("b2b_d2", snap_rd, shadow[15'h0020]);

    // Reset right after a p1 read grant drops that read
    apply_reset();
    set_req(0, 1, 0); p1_addr = 15'h0030; step(g);
    chk("mid_rst_grant", 32'(snap_ack), 32'b010);
    set_req(0, 1, 1);
    apply_reset();
    step(g);
    chk("post_rst_ack", 32'(snap_ack), 32'b010);
    chk("post_rst_no_stale", 32'(snap_vld), 32'b000);
    set_req(0, 0, 0);
    step(g); step(g); step(g);

    // Idle: bus quiet, address holds
    a0 = exp_addr;
    for (int k = 0; k < 10; k++) begin
      step(g);
      chk("idle_ack", 32'(snap_ack), 32'd0);
      chk("idle_wr", 32'({snap_bsel, snap_write}), 32'd0);
      chk("idle_addr", 32'(snap_addr), 32'(a0));
    end

    // Randomized traffic; requesters hold until acked
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      if (!p0_req || snap_ack[0]) begin
        p0_req = ($urandom_range(0, 9) < 7); p0_addr = rnd_addr();
      end
      if (!p1_req || snap_ack[1]) begin
        p1_req = ($urandom_range(0, 1) == 1); p1_addr = rnd_addr();
        p1_wrdata = $urandom; p1_wrbytesel = 4'($urandom_range(0, 15));
        p1_write = ($urandom_range(0, 1) == 1);
      end
      if (!p2_req || snap_ack[2]) begin
        p2_req = ($urandom_range(0, 1) == 1); p2_addr = rnd_addr();
        p2_wrdata = $urandom; p2_wrbytesel = 4'($urandom_range(0, 15));
        p2_write = ($urandom_range(0, 1) == 1);
      end
      step(g);
    end
    set_req(0, 0, 0);
    step(g); step(g); step(g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_ram_arbiter.md
MAIN_RAM_ARBITER -- requirements
Module: main_ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 15: maximum consecutive cycles ports 1/2 may be denied by port 0 while requesting.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n, listed first.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 p0_req / p0_addr  input  1 / 15  display fetch port, read-only: request and word address.
REQ-006 p0_ack / p0_rddata_valid  output  1 / 1  grant strobe and read-data-valid strobe.
REQ-007 p1_req, p1_addr[15], p1_wrdata[32], p1_wrbytesel[4], p1_write  input  host port request fields.
REQ-008 p1_ack, p1_rddata_valid  output  1 each  host port strobes.
REQ-009 p2_req, p2_addr[15], p2_wrdata[32], p2_wrbytesel[4], p2_write  input  auxiliary (DMA) port, same semantics as p1.
REQ-010 p2_ack, p2_rddata_valid  output  1 each  auxiliary port strobes.
REQ-011 rddata  output  32  broadcast read data, equal to ram_rddata.
REQ-012 ram_addr[15], ram_wrdata[32], ram_wrbytesel[4], ram_write  output, registered  RAM bus.
REQ-013 ram_rddata  input  32  RAM read data, valid one cycle after ram_addr.

Function
REQ-014 Arbitration SHALL be evaluated every cycle from current req inputs; at most one ack is high per cycle.
REQ-015 ack SHALL be combinational in the grant cycle N; requester holds req and fields stable until it sees ack, then may change them at edge N+1.
REQ-016 At edge ending cycle N the granted port's addr/wrdata/wrbytesel/write SHALL load into ram_*; with no grant, ram_write and ram_wrbytesel load 0 and ram_addr/ram_wrdata hold.
REQ-017 Priority: p0 over p1/p2 unless the starvation override is active; between p1 and p2, round-robin.
REQ-018 Round-robin register rr_last (1 bit) SHALL record which of p1/p2 was last granted; on simultaneous p1/p2 requests the port other than rr_last wins; a single requester wins regardless.
REQ-019 starve_cnt (4 bits min, width of STARVE_LIMIT) SHALL increment each cycle p0 is granted while p1_req or p2_req is high; SHALL clear when p1 or p2 is granted or neither requests.
REQ-020 When starve_cnt == STARVE_LIMIT, the next arbitration SHALL deny p0 and grant the round-robin winner of p1/p2.
REQ-021 Read grant in cycle N SHALL assert that port's rddata_valid for exactly cycle N+2, with rddata holding the word; write grants produce no valid strobe.
REQ-022 Valid tracking SHALL be a 2-stage pipeline of {read, port id}; back-to-back reads from any mix of ports SHALL each produce their own valid at N+2, one per cycle, in grant order.
REQ-023 Sustained throughput SHALL be one access per cycle with no idle cycles between grants.
REQ-024 p0 write is not supported; p0 grants always drive ram_write = 0.

Reset
REQ-025 While rst_n low: all ack outputs 0, all rddata_valid 0, ram_addr 0, ram_wrdata 0, ram_wrbytesel 0, ram_write 0, starve_cnt 0, rr_last = p2 (so p1 wins first tie), valid pipeline cleared.
REQ-026 Reset asserted mid-access SHALL discard in-flight valids; no rddata_valid SHALL appear after reset release for pre-reset grants.
REQ-027 First grant possible in the first cycle after rst_n deasserts.

Structure
REQ-028 Port-id encoding (P0=0, P1=1, P2=2) and STARVE_LIMIT default SHALL live in a shared package used by the arbiter and its requesters.
REQ-029 Single module; no sub-module required (grant logic inline).

Verification
REQ-030 p0 reads 0x0100 alone -> p0_ack cycle N, ram_addr=0x0100 at N+1, p0_rddata_valid at N+2 with rddata = RAM word.
REQ-031 p1 and p2 both write continuously (p1_wrbytesel=0xF, p2=0x3) -> acks alternate p1,p2,p1,... starting with p1; ram_write=1 every cycle.
REQ-032 p0 and p1 request continuously -> p0 granted 15 cycles, p1 granted cycle 16, pattern repeats; starve_cnt never exceeds 15.
REQ-033 Back-to-back reads p0@0x0010, p1@0x4010, p2@0x0020 in consecutive cycles -> valids p0, p1, p2 in consecutive cycles two cycles later, data matching each address.
REQ-034 rst_n pulsed low one cycle after a p1 read grant -> no p1_rddata_valid; all outputs at reset values; next p1/p2 tie grants p1.
REQ-035 No requests for 10 cycles -> ram_write=0, ram_wrbytesel=0, ram_addr unchanged, no acks.
